// File: rtl/serial_neg_ctrl.sv
// Feeds a parallel word LSB-first through an external bit-serial
// two's complementer and gathers the serial result into a word.
module serial_neg_ctrl #(
    parameter int W   = 4,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         r,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         ser_i,
    output logic         ser_r,
    input  logic         ser_y,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    input  logic         out_ready,
    output logic         busy
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [W-1:0] OVF_PAT = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  sh;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_nxt;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          cap;
    logic          last;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ser_i     = 1'b0;
        ser_r     = r;
        out_valid = 1'b0;
        cap       = 1'b0;
        last      = (cnt == LAST);
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CLR;
            end
            CLR: begin
                ser_r     = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                ser_i = sh[0];
                // a registered complementer returns bit 0 one cycle late
                cap   = (LAT == 0) || (cnt != '0);
                if (last) state_nxt = (LAT == 1) ? DRAIN : DONE;
            end
            DRAIN: begin
                cap       = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy    = (state != IDLE);
        accept  = in_ready && in_valid;
        acc_nxt = cap ? {ser_y, acc[W-1:1]} : acc;
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state    <= IDLE;
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= accept ? '0 : acc_nxt;
            if (accept) begin
                sh      <= in_data;
                out_ovf <= (in_data == OVF_PAT);
            end else if (state == SHIFT) begin
                sh <= {1'b0, sh[W-1:1]};
            end
            if (state == SHIFT && !last) cnt <= cnt + 1'b1;
            else cnt <= '0;
            // result word is only published as DONE is entered
            if (state != DONE && state_nxt == DONE) out_data <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_serial_neg_ctrl.sv
// Directed bench for serial_neg_ctrl with W=4, one instance per LAT value,
// each wired to a behavioural bit-serial complementer.
module tb_serial_neg_ctrl;

    logic       clk;
    logic       r;
    logic       iv0, iv1, or0, or1;
    logic [3:0] id0, id1;
    logic       rdy0, rdy1, si0, si1, sr0, sr1, sy0, sy1;
    logic       ov0, ov1, of0, of1, bz0, bz1;
    logic [3:0] od0, od1;
    logic       seen0, seen1, yq1;

    int n_checks = 0;
    int n_err    = 0;

    serial_neg_ctrl #(.W(4), .LAT(0)) dut0 (
        .clk(clk), .r(r), .in_valid(iv0), .in_data(id0),
        .in_ready(rdy0), .ser_i(si0), .ser_r(sr0), .ser_y(sy0),
        .out_valid(ov0), .out_data(od0), .out_ovf(of0),
        .out_ready(or0), .busy(bz0)
    );

    serial_neg_ctrl #(.W(4), .LAT(1)) dut1 (
        .clk(clk), .r(r), .in_valid(iv1), .in_data(id1),
        .in_ready(rdy1), .ser_i(si1), .ser_r(sr1), .ser_y(sy1),
        .out_valid(ov1), .out_data(od1), .out_ovf(of1),
        .out_ready(or1), .busy(bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // complementer: y = i XOR (a 1 was seen since the last clear)
    always_ff @(posedge clk) begin
        if (sr0) seen0 <= 1'b0;
        else if (si0) seen0 <= 1'b1;
    end
    assign sy0 = si0 ^ seen0;

    always_ff @(posedge clk) begin
        if (sr1) seen1 <= 1'b0;
        else if (si1) seen1 <= 1'b1;
        yq1 <= si1 ^ seen1;
    end
    assign sy1 = yq1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_wait(input int sel, input logic [3:0] d,
                            input string tag);
        int         n;
        int         nclr;
        logic [3:0] bits;
        logic       v;
        n    = 0;
        nclr = 0;
        bits = '0;
        v    = 1'b0;
        chk({tag, "_rdy"}, 32'(sel != 0 ? rdy1 : rdy0), 32'd1);
        if (sel == 0) begin iv0 = 1'b1; id0 = d; end
        else begin iv1 = 1'b1; id1 = d; end
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        iv1 = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (sel != 0 ? sr1 : sr0) nclr++;
            if (n >= 2 && n <= 5) bits[n-2] = (sel != 0) ? si1 : si0;
            v = (sel != 0) ? ov1 : ov0;
        end while (!v && n < 20);
        chk({tag, "_lat"}, 32'(n - 1), 32'(5 + sel));
        chk({tag, "_seq"}, 32'(bits), 32'(d));
        chk({tag, "_clr"}, 32'(nclr), 32'd1);
    endtask

    task automatic finish_tx(input int sel, input logic [3:0] exp,
                             input logic ovf, input string tag);
        chk({tag, "_data"}, 32'(sel != 0 ? od1 : od0), 32'(exp));
        chk({tag, "_ovf"}, 32'(sel != 0 ? of1 : of0), 32'(ovf));
        if (sel == 0) or0 = 1'b1;
        else or1 = 1'b1;
        @(posedge clk);
        #1;
        or0 = 1'b0;
        or1 = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, 32'(sel != 0 ? rdy1 : rdy0), 32'd1);
        chk({tag, "_ovld"}, 32'(sel != 0 ? ov1 : ov0), 32'd0);
    endtask

    initial begin
        logic       stable_ok;
        logic [3:0] res [2];
        logic       acc_now;
        int         nres;
        int         nclr;
        int         nacc;

        r   = 1'b1;
        iv0 = 1'b0; iv1 = 1'b0;
        or0 = 1'b0; or1 = 1'b0;
        id0 = '0;   id1 = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_serr0", 32'(sr0), 32'd1);
        chk("rst_serr1", 32'(sr1), 32'd1);
        chk("rst_ovld", 32'(ov0), 32'd0);
        chk("rst_data", 32'(od0), 32'd0);
        chk("rst_ovf", 32'(of0), 32'd0);
        chk("rst_busy", 32'(bz0), 32'd0);
        chk("rst_seri", 32'(si0), 32'd0);
        r = 1'b0;
        @(negedge clk);
        chk("rel_rdy", 32'(rdy0), 32'd1);
        chk("rel_serr", 32'(sr0), 32'd0);

        // basic negation, LAT=0
        run_wait(0, 4'b0011, "s1");
        finish_tx(0, 4'b1101, 1'b0, "s1");

        // zero and the unrepresentable minimum
        run_wait(0, 4'b0000, "s2a");
        finish_tx(0, 4'b0000, 1'b0, "s2a");
        run_wait(0, 4'b1000, "s2b");
        finish_tx(0, 4'b1000, 1'b1, "s2b");

        // registered complementer, LAT=1
        run_wait(1, 4'b0110, "s3");
        finish_tx(1, 4'b1010, 1'b0, "s3");

        // consumer stalls while DONE; new offers must be ignored
        run_wait(0, 4'b0101, "s4");
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iv0 = (i == 3 || i == 6);
            id0 = 4'b1111;
            @(negedge clk);
            if (od0 !== 4'b1011 || of0 !== 1'b0 || ov0 !== 1'b1 ||
                rdy0 !== 1'b0 || bz0 !== 1'b1)
                stable_ok = 1'b0;
        end
        iv0 = 1'b0;
        chk("s4_stable", 32'(stable_ok), 32'd1);
        finish_tx(0, 4'b1011, 1'b0, "s4");

        // reset in the second SHIFT cycle
        iv0 = 1'b1;
        id0 = 4'b0101;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("s5_busy_pre", 32'(bz0), 32'd1);
        r = 1'b1;
        #1;
        chk("s5_serr_r", 32'(sr0), 32'd1);
        @(posedge clk);
        #1;
        chk("s5_serr_hold", 32'(sr0), 32'd1);
        chk("s5_busy", 32'(bz0), 32'd0);
        chk("s5_ovld", 32'(ov0), 32'd0);
        chk("s5_seri", 32'(si0), 32'd0);
        chk("s5_data", 32'(od0), 32'd0);
        r = 1'b0;
        @(negedge clk);
        run_wait(0, 4'b0001, "s5n");
        finish_tx(0, 4'b1111, 1'b0, "s5n");

        // back-to-back with in_valid and out_ready held high
        nres = 0;
        nclr = 0;
        nacc = 0;
        res[0] = '0;
        res[1] = '0;
        iv0 = 1'b1;
        id0 = 4'b0001;
        or0 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (ov0) begin
                if (nres < 2) res[nres] = od0;
                nres++;
            end
            if (sr0) nclr++;
            acc_now = rdy0 && iv0;
            @(posedge clk);
            #1;
            if (acc_now) begin
                nacc++;
                if (nacc == 1) id0 = 4'b0111;
                else iv0 = 1'b0;
            end
            @(negedge clk);
        end
        or0 = 1'b0;
        chk("s6_nacc", 32'(nacc), 32'd2);
        chk("s6_nres", 32'(nres), 32'd2);
        chk("s6_res0", 32'(res[0]), 32'(4'b1111));
        chk("s6_res1", 32'(res[1]), 32'(4'b1001));
        chk("s6_clr", 32'(nclr), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/serial_neg_ctrl.md
SERIAL_NEG_CTRL -- requirements
Module: serial_neg_ctrl

Interface
REQ-001 SHALL have parameter W, default 4, meaning word width in bits (W >= 2).
REQ-002 SHALL have parameter LAT, default 0, meaning the serial unit's delay from ser_i to ser_y in clock cycles (legal values 0 or 1 only).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port r, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning a parallel word is offered.
REQ-006 SHALL have port in_data, input, W, the word to negate (two's complement).
REQ-007 SHALL have port in_ready, output, 1, meaning the controller can accept a word.
REQ-008 SHALL have port ser_i, output, 1, the serial bit to the bit-serial complementer (LSB first).
REQ-009 SHALL have port ser_r, output, 1, the clear for the bit-serial complementer (active high).
REQ-010 SHALL have port ser_y, input, 1, the serial result bit from the complementer.
REQ-011 SHALL have port out_valid, output, 1, meaning a result is held.
REQ-012 SHALL have port out_data, output, W, the two's complement of the accepted word.
REQ-013 SHALL have port out_ovf, output, 1, meaning the accepted word was 1 followed by W-1 zeros (the negation is unrepresentable).
REQ-014 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CLR, SHIFT, DRAIN, DONE.
REQ-017 IDLE: in_ready=1; in_valid=1 at an edge latches in_data into the shift register, latches out_ovf, clears the result register, and moves to CLR.
REQ-018 CLR: lasts 1 cycle with ser_r=1 and ser_i=0, then moves to SHIFT.
REQ-019 SHIFT: lasts exactly W cycles; in cycle j (0..W-1) ser_i = bit j of the latched word; a bit counter counts 0..W-1 with no wrap beyond W-1; then moves to DRAIN if LAT=1, otherwise to DONE.
REQ-020 DRAIN: lasts LAT cycles with ser_i=0 and ser_r=0, then moves to DONE.
REQ-021 Capture: ser_y is sampled in the W consecutive cycles starting LAT cycles after the first SHIFT cycle; each sample shifts in at the MSB, so the first sample lands in bit 0 after W shifts.
REQ-022 DONE: out_valid=1; out_data and out_ovf stay stable until out_ready=1 at an edge, then the FSM moves to IDLE.
REQ-023 Latency: out_valid rises exactly 1+W+LAT edges after the accepting edge.
REQ-024 Outside CLR, ser_r = r; outside SHIFT, ser_i = 0.
REQ-025 in_ready=0 in every state except IDLE; in_valid outside IDLE is ignored and the word is not stored.
REQ-026 out_ready while out_valid=0 is ignored.
REQ-027 With out_valid and out_ready both high at an edge, in_ready=1 in the next cycle; no word is accepted in that same edge.
REQ-028 out_data after a new acceptance is undefined-free: it holds the previous result until DONE is re-entered, and out_valid=0 until then.

Reset
REQ-029 r=1 at an edge SHALL force IDLE from any state, including mid-SHIFT, discarding the in-flight word.
REQ-030 The same reset edge SHALL drive out_valid=0, out_data=0, out_ovf=0, ser_i=0, and busy=0, and SHALL leave in_ready=1 after release.
REQ-031 ser_r SHALL be 1 for every cycle r=1.
REQ-032 r has priority over in_valid and out_ready in the same cycle.

Verification (W=4; bench models the serial unit as y = i XOR (a 1 was seen since the last clear))
REQ-033 Scenario 1: LAT=0, in_data=0011 -> out_data=1101, out_ovf=0, out_valid 5 edges after acceptance, ser_i sequence 1,1,0,0.
REQ-034 Scenario 2: in_data=0000 -> out_data=0000, out_ovf=0; in_data=1000 -> out_data=1000, out_ovf=1.
REQ-035 Scenario 3: LAT=1, in_data=0110 -> out_data=1010, with out_valid 6 edges after acceptance.
REQ-036 Scenario 4: out_ready held low for 10 cycles in DONE -> out_data is stable; in_valid pulses during this time are not accepted; after out_ready=1, IDLE is reached the next cycle.
REQ-037 Scenario 5: r pulsed in the 2nd SHIFT cycle of word 0101 -> IDLE, out_valid=0, ser_r=1 during reset; the next word 0001 -> 1111.
REQ-038 Scenario 6: back-to-back words 0001, 0111 with in_valid held high -> results 1111 then 1001; ser_r=1 exactly once per word.
